// File: rtl/contador_pkg.sv
// Shared types and helpers for the modulo-N counter family.
package contador_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } cnt_op_e;

  // Highest legal count (MOD-1), masked to the counter width.
  function automatic longint unsigned max_val(input int unsigned width,
                                              input longint unsigned modulus);
    longint unsigned mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (modulus - 64'd1) & mask;
  endfunction

endpackage

// File: rtl/reg_ar_n.sv
// WIDTH-bit D register with asynchronous active-low reset to zero.
module reg_ar_n #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/contador_mod_n.sv
// Modulo-MOD up/down counter with load, clear, terminal count and sticky wrap flag.
module contador_mod_n #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);
  import contador_pkg::*;

  if (WIDTH < 1 || MOD < 2 || (WIDTH < 31 && MOD > (1 << WIDTH))) begin : g_param_err
    $error("contador_mod_n: illegal WIDTH/MOD combination");
  end

  // All boundary compares are WIDTH bits wide; MOD==2**WIDTH never needs WIDTH+1 bits.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_val(WIDTH, MOD));

  cnt_op_e          op;
  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] load_val;
  logic             ovf_d, ovf_q;
  logic             at_max, at_zero;

  always_comb begin
    op = OP_HOLD;
    if (clr)     op = OP_CLR;
    else if (ld) op = OP_LOAD;
    else if (en) op = up ? OP_INC : OP_DEC;
  end

  assign at_max   = (q_q == MAX_Q);
  assign at_zero  = (q_q == '0);
  assign load_val = (d > MAX_Q) ? MAX_Q : d;

  always_comb begin
    tc = ((op == OP_INC) && at_max) || ((op == OP_DEC) && at_zero);
  end

  always_comb begin
    q_d = q_q;
    unique case (op)
      OP_CLR:  q_d = '0;
      OP_LOAD: q_d = load_val;
      OP_INC:  q_d = at_max  ? '0    : q_q + WIDTH'(1);
      OP_DEC:  q_d = at_zero ? MAX_Q : q_q - WIDTH'(1);
      default: q_d = q_q;
    endcase
  end

  // A wrap outranks a coincident clear so that no wrap event is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (tc)                 ovf_d = 1'b1;
    else if (ovf_clr || clr) ovf_d = 1'b0;
  end

  reg_ar_n #(.WIDTH(WIDTH)) u_q_reg (
    .clk   (clk),
    .rst_n (rst),
    .d     (q_d),
    .q     (q_q)
  );

  reg_ar_n #(.WIDTH(1)) u_ovf_reg (
    .clk   (clk),
    .rst_n (rst),
    .d     (ovf_d),
    .q     (ovf_q)
  );

  assign Q   = q_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_contador_mod_n.sv
// Scoreboard bench for contador_mod_n: MOD=10 and MOD=16 instances share stimulus.
module tb_contador_mod_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, ld = 1'b0, ovf_clr = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q10, q16;
  logic       tc10, tc16, ovf10, ovf16;

  always #5 clk = ~clk;

  contador_mod_n #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld), .d(d),
    .ovf_clr(ovf_clr), .Q(q10), .tc(tc10), .ovf(ovf10)
  );

  contador_mod_n #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .ld(ld), .d(d),
    .ovf_clr(ovf_clr), .Q(q16), .tc(tc16), .ovf(ovf16)
  );

  typedef struct {
    int q[2];
    int o[2];
    int t[2];
  } exp_t;

  exp_t sb[$];
  int   mq[2];
  int   mo[2];
  int   mods[2] = '{10, 16};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference: count as an integer modulo m; a wrap is an enabled step whose raw result leaves 0..m-1.
  task automatic step(input bit r, input bit e, input bit u, input bit c,
                      input bit l, input bit oc, input int dv);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; up = u; clr = c; ld = l; ovf_clr = oc; d = 4'(dv);
    for (int k = 0; k < 2; k++) begin
      int  m;
      int  raw;
      bit  wrap;
      m = mods[k];
      if (!r) begin
        mq[k] = 0;
        mo[k] = 0;
      end
      raw  = u ? mq[k] + 1 : mq[k] - 1;
      wrap = e && !c && !l && (raw < 0 || raw >= m);
      x.q[k] = mq[k];
      x.o[k] = mo[k];
      x.t[k] = int'(wrap);
      if (r) begin
        if (c)      mq[k] = 0;
        else if (l) mq[k] = (dv < m) ? dv : m - 1;
        else if (e) mq[k] = (mq[k] + (u ? 1 : m - 1)) % m;
        if (wrap)          mo[k] = 1;
        else if (c || oc)  mo[k] = 0;
      end
    end
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("q_mod10",    int'(q10),   e.q[0]);
      chk("ovf_mod10",  int'(ovf10), e.o[0]);
      chk("tc_mod10",   int'(tc10),  e.t[0]);
      chk("range_mod10", int'(q10 < 4'd10), 1);
      chk("q_mod16",    int'(q16),   e.q[1]);
      chk("ovf_mod16",  int'(ovf16), e.o[1]);
      chk("tc_mod16",   int'(tc16),  e.t[1]);
    end
  end

  initial begin
    int drained;
    // reset, then count up through the 9->0 wrap
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0, 0, 0);
    // reset asserted mid-cycle with en=1, up=0: Q/ovf cleared at once, tc high
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0);
    // direction change at Q=9
    step(1, 0, 1, 0, 1, 0, 9);
    step(1, 1, 0, 0, 0, 0, 0);
    // loads: plain, clamped, clear beats load, load beats count at terminal
    step(1, 0, 1, 0, 1, 0, 7);
    step(1, 0, 1, 0, 1, 0, 13);
    step(1, 0, 1, 1, 1, 0, 5);
    step(1, 0, 1, 0, 1, 0, 9);
    step(1, 1, 1, 0, 1, 0, 9);
    step(1, 0, 1, 0, 0, 0, 0);
    // wrap coinciding with ovf_clr keeps ovf; bare ovf_clr clears it
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 9);
    step(1, 1, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    // full-range wrap up 15->0 and down 0->15
    step(1, 0, 1, 0, 1, 0, 15);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    // random soak
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(199) != 0),
           ($urandom_range(3) != 0),
           1'($urandom_range(1)),
           ($urandom_range(15) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(7) == 0),
           int'($urandom_range(15)));
    end
    step(1, 0, 1, 0, 0, 0, 0);
    drained = 0;
    for (int i = 0; i < 5 && !drained; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) drained = 1;
    end
    if (!drained) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/contador_mod_n.md
Name: contador_mod_n

Overview:
Parametrised successor to the 4-bit up counter in the ALU datapath. It counts modulo MOD, up or down, with synchronous load, synchronous clear, a terminal-count output and a sticky wrap flag. It serves as the generic step, timer and digit counter for ALU sequencing and display blocks. The state register uses asynchronous active-low reset.

Parameters:
WIDTH, 4, counter width in bits (>= 1)
MOD, 16, count modulus; legal range 2..2**WIDTH; count spans 0..MOD-1

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
clr  input  1  synchronous clear of Q to 0
ld  input  1  synchronous load of d
d  input  WIDTH  load value
ovf_clr  input  1  synchronous clear of ovf
Q  output  WIDTH  current count
tc  output  1  terminal count, combinational
ovf  output  1  sticky wrap flag, registered

Behaviour:
- Reset is asynchronous and active-low. While rst=0: Q=0 and ovf=0 immediately, independent of clk. tc follows Q and en combinationally, so it can be 1 during reset (en=1, up=0, Q=0). Release takes effect at the next rising edge.
- Q update priority on each rising edge with rst=1:
  1. clr=1: Q<=0.
  2. Else ld=1: Q<=d if d<MOD; otherwise Q<=MOD-1 (clamped).
  3. Else en=1 and up=1: Q<=Q+1, or 0 when Q==MOD-1.
  4. Else en=1 and up=0: Q<=Q-1, or MOD-1 when Q==0.
  5. Else Q holds.
- tc = en & ~clr & ~ld & ((up & Q==MOD-1) | (~up & Q==0)). It is asserted in the same cycle as the edge that wraps.
- wrap_evt = tc. On the edge where wrap_evt=1, ovf<=1.
- ovf is cleared by ovf_clr=1 or clr=1. If a set and a clear coincide in the same cycle, the set wins: ovf<=1, so no wrap is lost.
- Latency: Q changes 1 cycle after the control input is sampled. tc has zero latency relative to Q, en and up.
- Direction change mid-count takes effect on the next edge, with no glitch cycle. Example: MOD=10, Q=9, up goes 1->0 with en=1 gives next Q=8 and tc=0.
- When MOD==2**WIDTH, the wrap is the natural binary overflow. The implementation must not need a WIDTH+1 comparator in that case.
- Q never leaves 0..MOD-1 by any input sequence.
- Next-state arithmetic is done in WIDTH bits. Comparisons use constants derived from MOD, cast to WIDTH.
- Elaboration fails on illegal parameters: MOD<2, MOD>2**WIDTH, or WIDTH<1.

Decomposition:
- Shared package contador_pkg:
  - cnt_op_e enum: OP_HOLD, OP_CLR, OP_LOAD, OP_INC, OP_DEC
  - function max_val(WIDTH, MOD) returning MOD-1 as WIDTH bits
- One natural sub-module, reg_ar_n: a WIDTH-parametrised D register with asynchronous active-low reset to 0.
  - Instantiate it for Q (width WIDTH) and for ovf (width 1).
- Next-state, operation select, clamp and tc logic live in contador_mod_n as combinational logic.

Test Plan:
- Apply reset with WIDTH=4, MOD=10: rst=0 mid-cycle forces Q=0 and ovf=0 before the next edge.
- Count up through wrap: en=1, up=1 for 12 cycles from Q=0 gives Q sequence 0..9,0,1,2. tc=1 only while Q=9. ovf becomes 1 after the 9->0 edge.
- Count down through wrap: from reset with en=1, up=0, Q sequence is 9,8,... tc=1 in the first cycle (Q=0). ovf=1 after the 0->9 edge.
- Load with clamp and priority:
  - d=7, ld=1 gives Q=7.
  - d=13, ld=1 gives Q=9.
  - clr=1 together with ld=1 and d=5 gives Q=0.
  - ld=1 with en=1 and Q=9 gives tc=0 and ovf unchanged.
- Simultaneous ovf set and clear: ovf=1, then ovf_clr=1 in the same cycle as a 9->0 wrap keeps ovf=1. ovf_clr=1 with no wrap on the next cycle gives ovf=0.
- Full-range config with WIDTH=4, MOD=16: up wraps 15->0 with tc=1 at 15; down wraps 0->15. Run 10k random cycles with a reference model to check Q<MOD always and that tc matches ovf set events.
